// File: rtl/output_fifo_drain_pkg.sv
// ---------------------------------------------------------------------------
// output_fifo_drain_pkg
// Shared definitions for the output FIFO drain block.
//   state_t   : drain FSM state encoding (IDLE/READ/LATCH/PRESENT)
//   STATUS_OK : status token value that means "success"
// ---------------------------------------------------------------------------
package output_fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        READ    = 2'b01,
        LATCH   = 2'b10,
        PRESENT = 2'b11
    } state_t;

    localparam int STATUS_OK = 0;

endpackage

// File: rtl/output_fifo_drain_desync_monitor.sv
// ---------------------------------------------------------------------------
// output_fifo_drain_desync_monitor
// Watches the result/status FIFO populations and raises a sticky flag once
// exactly one of them has been empty for desync_timeout consecutive cycles.
// Ports:
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   result_empty : result FIFO population is zero
//   status_empty : status FIFO population is zero
//   desync       : sticky desynchronisation flag, cleared only by reset
// ---------------------------------------------------------------------------
module output_fifo_drain_desync_monitor
    import output_fifo_drain_pkg::*;
#(
    parameter int desync_timeout = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic result_empty,
    input  logic status_empty,
    output logic desync
);

    localparam int CW = $clog2(desync_timeout + 1);
    localparam logic [CW-1:0] LIMIT = CW'(desync_timeout);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          desync_reg;

    // Count only while the two FIFOs disagree on emptiness; any agreement
    // (both empty or both holding tokens) restarts the window.
    always_comb begin
        count_next = '0;
        if (result_empty != status_empty) begin
            count_next = (count_reg == LIMIT) ? count_reg : count_reg + 1'b1;
        end
    end

    // The flag is set on the same edge the counter reaches the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg  <= '0;
            desync_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (count_next == LIMIT) begin
                desync_reg <= 1'b1;
            end
        end
    end

    assign desync = desync_reg;

endmodule

// File: rtl/output_fifo_drain.sv
// ---------------------------------------------------------------------------
// output_fifo_drain
// Reader end of the result/status output FIFO pair. Pops one token from each
// FIFO together, latches the pair and presents it on a valid/ready host
// interface. Counts accepted pairs and flags FIFO desynchronisation.
// Optional feature macro: STATUS_ERR_CNT_EN adds err_count, a saturating
// count of accepted pairs whose status is not STATUS_OK.
// Ports:
//   clk, rst              : clock (rising edge), async active-low reset
//   pop_out_fifo_result   : result FIFO population
//   pop_out_fifo_status   : status FIFO population
//   data_in_result/status : FIFO read data, valid the cycle after the read
//   en_rd_fifo_result/status : FIFO read enables (always asserted together)
//   host_ready            : host accepts the presented pair
//   host_valid            : pair presented to host
//   host_result/status    : latched pair
//   pairs_drained         : accepted pairs, wraps
//   desync                : sticky desynchronisation flag
//   err_count             : (STATUS_ERR_CNT_EN only) non-OK status count
// ---------------------------------------------------------------------------
module output_fifo_drain
    import output_fifo_drain_pkg::*;
#(
    parameter int word_size      = 16,
    parameter int desync_timeout = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] pop_out_fifo_result,
    input  logic [word_size-1:0] pop_out_fifo_status,
    input  logic [word_size-1:0] data_in_result,
    input  logic [word_size-1:0] data_in_status,
    output logic                 en_rd_fifo_result,
    output logic                 en_rd_fifo_status,
    input  logic                 host_ready,
    output logic                 host_valid,
    output logic [word_size-1:0] host_result,
    output logic [word_size-1:0] host_status,
    output logic [word_size-1:0] pairs_drained,
    output logic                 desync
`ifdef STATUS_ERR_CNT_EN
    ,
    output logic [word_size-1:0] err_count
`endif
);

    state_t               state_reg;
    state_t               state_next;
    logic [word_size-1:0] host_result_reg;
    logic [word_size-1:0] host_status_reg;
    logic [word_size-1:0] pairs_reg;
    logic                 both_nonempty;
    logic                 transfer;

    assign both_nonempty = (pop_out_fifo_result != '0) && (pop_out_fifo_status != '0);
    assign transfer      = (state_reg == PRESENT) && host_ready;

    // Next-state logic. Populations are only looked at in IDLE, so changes
    // during a transfer are ignored until it completes.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (both_nonempty) state_next = READ;
            READ:    state_next = LATCH;
            LATCH:   state_next = PRESENT;
            PRESENT: if (host_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            host_result_reg <= '0;
            host_status_reg <= '0;
            pairs_reg       <= '0;
        end else begin
            state_reg <= state_next;
            // Read data arrives one cycle after the enable, i.e. during LATCH.
            if (state_reg == LATCH) begin
                host_result_reg <= data_in_result;
                host_status_reg <= data_in_status;
            end
            if (transfer) begin
                pairs_reg <= pairs_reg + 1'b1;
            end
        end
    end

`ifdef STATUS_ERR_CNT_EN
    logic [word_size-1:0] err_count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count_reg <= '0;
        end else if (transfer && (host_status_reg != word_size'(STATUS_OK))
                     && (err_count_reg != '1)) begin
            err_count_reg <= err_count_reg + 1'b1;
        end
    end

    assign err_count = err_count_reg;
`endif

    // Moore outputs decoded from state.
    assign en_rd_fifo_result = (state_reg == READ);
    assign en_rd_fifo_status = (state_reg == READ);
    assign host_valid        = (state_reg == PRESENT);
    assign host_result       = host_result_reg;
    assign host_status       = host_status_reg;
    assign pairs_drained     = pairs_reg;

    output_fifo_drain_desync_monitor #(
        .desync_timeout(desync_timeout)
    ) u_desync_monitor (
        .clk         (clk),
        .rst         (rst),
        .result_empty(pop_out_fifo_result == '0),
        .status_empty(pop_out_fifo_status == '0),
        .desync      (desync)
    );

endmodule

// File: tb/tb_output_fifo_drain.sv
// ---------------------------------------------------------------------------
// tb_output_fifo_drain
// Self-checking bench for output_fifo_drain. The bench emulates the two
// output FIFOs with queues (populations = queue sizes, read data one cycle
// after the enable) and keeps a reference model: expected pair order,
// accepted-pair count, non-OK status count and the desync rule.
// ---------------------------------------------------------------------------
module tb_output_fifo_drain;

    localparam int WS = 16;
    localparam int T  = 8;

    logic          clk;
    logic          rst;
    logic [WS-1:0] pop_r;
    logic [WS-1:0] pop_s;
    logic [WS-1:0] data_in_result;
    logic [WS-1:0] data_in_status;
    logic          en_rd_fifo_result;
    logic          en_rd_fifo_status;
    logic          host_ready;
    logic          host_valid;
    logic [WS-1:0] host_result;
    logic [WS-1:0] host_status;
    logic [WS-1:0] pairs_drained;
    logic          desync;
`ifdef STATUS_ERR_CNT_EN
    logic [WS-1:0] err_count;
`endif

    output_fifo_drain #(
        .word_size     (WS),
        .desync_timeout(T)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .pop_out_fifo_result(pop_r),
        .pop_out_fifo_status(pop_s),
        .data_in_result     (data_in_result),
        .data_in_status     (data_in_status),
        .en_rd_fifo_result  (en_rd_fifo_result),
        .en_rd_fifo_status  (en_rd_fifo_status),
        .host_ready         (host_ready),
        .host_valid         (host_valid),
        .host_result        (host_result),
        .host_status        (host_status),
        .pairs_drained      (pairs_drained),
        .desync             (desync)
`ifdef STATUS_ERR_CNT_EN
        ,
        .err_count          (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO emulation and reference model state
    logic [WS-1:0] q_res[$];
    logic [WS-1:0] q_sta[$];
    logic [WS-1:0] exp_r[$];
    logic [WS-1:0] exp_s[$];
    int            xfer_cycles[$];
    int            tests = 0;
    int            fails = 0;
    int            cycle = 0;
    int            mpairs = 0;
    int            merr = 0;
    int            dcnt = 0;
    logic          mdes = 1'b0;
    logic          prev_rd = 1'b0;

    typedef struct {
        logic [WS-1:0] res;
        logic [WS-1:0] sta;
        int            stall;
        int            exp_pairs;
        int            exp_err;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic model_reset();
        mpairs  = 0;
        merr    = 0;
        dcnt    = 0;
        mdes    = 1'b0;
        prev_rd = 1'b0;
    endtask

    task automatic push_res(input logic [WS-1:0] v);
        q_res.push_back(v);
        exp_r.push_back(v);
        pop_r = WS'(q_res.size());
    endtask

    task automatic push_sta(input logic [WS-1:0] v);
        q_sta.push_back(v);
        exp_s.push_back(v);
        pop_s = WS'(q_sta.size());
    endtask

    // One clock cycle: update the model from the current cycle, cross the
    // edge, emulate FIFO reads, then check the DUT against the model.
    task automatic tick();
        logic          rd_r;
        logic          rd_s;
        logic          xfer;
        logic          was_valid;
        logic [WS-1:0] hr;
        logic [WS-1:0] hs;
        logic [WS-1:0] er;
        logic [WS-1:0] es;
        rd_r      = en_rd_fifo_result;
        rd_s      = en_rd_fifo_status;
        xfer      = host_valid && host_ready && rst;
        was_valid = host_valid && rst;
        hr        = host_result;
        hs        = host_status;
        check("rd_pair", int'(rd_s), int'(rd_r));
        if (rd_r) begin
            check("rd_when_both_nonempty", int'(pop_r != 0 && pop_s != 0), 1);
            check("rd_single_cycle", int'(prev_rd), 0);
            check("rd_not_while_valid", int'(host_valid), 0);
        end
        prev_rd = rd_r;
        if (rst) begin
            if ((pop_r == 0) != (pop_s == 0)) begin
                if (dcnt < T) dcnt++;
            end else begin
                dcnt = 0;
            end
            if (dcnt == T) mdes = 1'b1;
            if (xfer) begin
                if (exp_r.size() == 0 || exp_s.size() == 0) begin
                    check("xfer_expected", 0, 1);
                end else begin
                    er = exp_r.pop_front();
                    es = exp_s.pop_front();
                    check("host_result", int'(hr), int'(er));
                    check("host_status", int'(hs), int'(es));
                end
                mpairs = (mpairs + 1) % 65536;
                if (hs != 0 && merr != 65535) merr++;
                xfer_cycles.push_back(cycle);
                $display("[TB] transfer cycle=%0d result=%04h status=%04h", cycle, hr, hs);
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        if (rd_r) begin
            if (q_res.size() == 0 || q_sta.size() == 0) begin
                check("read_from_empty", 1, 0);
            end else begin
                data_in_result = q_res.pop_front();
                data_in_status = q_sta.pop_front();
            end
        end
        pop_r = WS'(q_res.size());
        pop_s = WS'(q_sta.size());
        check("pairs_drained", int'(pairs_drained), mpairs);
        check("desync", int'(desync), int'(mdes));
`ifdef STATUS_ERR_CNT_EN
        check("err_count", int'(err_count), merr);
`endif
        if (was_valid && !xfer) begin
            check("valid_hold", int'(host_valid), 1);
            check("result_hold", int'(host_result), int'(hr));
            check("status_hold", int'(host_status), int'(hs));
        end
    endtask

    task automatic wait_valid(input string name, input int req_cycles);
        int n;
        n = 0;
        while (!host_valid && n < 20) begin
            tick();
            n++;
        end
        check(name, n, req_cycles);
    endtask

    task automatic drain_all(input int bound);
        int n;
        n = 0;
        host_ready = 1'b1;
        while ((exp_r.size() > 0 || host_valid) && n < bound) begin
            tick();
            n++;
        end
        check("drain_complete", exp_r.size(), 0);
    endtask

    initial begin
        int c0;
        int base;
        vecs[0] = '{res: 16'h0042, sta: 16'h0000, stall: 0, exp_pairs: 1, exp_err: 0};
        vecs[1] = '{res: 16'h1234, sta: 16'h0003, stall: 5, exp_pairs: 2, exp_err: 1};
        vecs[2] = '{res: 16'h00ff, sta: 16'h0000, stall: 0, exp_pairs: 3, exp_err: 1};
        vecs[3] = '{res: 16'hbeef, sta: 16'h0007, stall: 2, exp_pairs: 4, exp_err: 2};

        rst            = 1'b0;
        pop_r          = '0;
        pop_s          = '0;
        data_in_result = '0;
        data_in_status = '0;
        host_ready     = 1'b0;
        model_reset();
        tick();
        tick();
        check("reset_valid", int'(host_valid), 0);
        check("reset_rd", int'(en_rd_fifo_result | en_rd_fifo_status), 0);
        check("reset_result", int'(host_result), 0);
        check("reset_status", int'(host_status), 0);
        rst = 1'b1;
        tick();

        // Table: latency, stall hold, pair count and status-error count
        for (int i = 0; i < 4; i++) begin
            host_ready = 1'b0;
            push_res(vecs[i].res);
            push_sta(vecs[i].sta);
            wait_valid("first_valid_latency", 3);
            for (int s = 0; s < vecs[i].stall; s++) tick();
            host_ready = 1'b1;
            tick();
            check("table_valid_dropped", int'(host_valid), 0);
            check("table_pairs", int'(pairs_drained), vecs[i].exp_pairs);
`ifdef STATUS_ERR_CNT_EN
            check("table_err", int'(err_count), vecs[i].exp_err);
`endif
            tick();
        end

        // Desync: result FIFO holds 3, status FIFO empty
        base = mpairs;
        push_res(16'h0a01);
        push_res(16'h0a02);
        push_res(16'h0a03);
        for (int i = 0; i < T; i++) begin
            if (i == T - 1) check("desync_before_timeout", int'(desync), 0);
            tick();
            check("no_rd_on_desync", int'(en_rd_fifo_result), 0);
        end
        check("desync_at_timeout", int'(desync), 1);
        push_sta(16'h0000);
        push_sta(16'h0000);
        push_sta(16'h0000);
        drain_all(100);
        check("desync_sticky", int'(desync), 1);
        check("desync_pairs", int'(pairs_drained), base + 3);

        // Back-to-back: four pairs, host always ready
        tick();
        base = mpairs;
        xfer_cycles.delete();
        host_ready = 1'b1;
        c0 = cycle;
        for (int i = 0; i < 4; i++) begin
            push_res(WS'(16'h0b00 + i));
            push_sta(WS'(i));
        end
        drain_all(100);
        check("b2b_count", xfer_cycles.size(), 4);
        if (xfer_cycles.size() == 4) begin
            check("b2b_first", xfer_cycles[0] - c0, 3);
            for (int i = 1; i < 4; i++) check("b2b_spacing", xfer_cycles[i] - xfer_cycles[i-1], 4);
        end
        check("b2b_pairs", int'(pairs_drained), base + 4);
        tick();
        check("b2b_idle", int'(host_valid | en_rd_fifo_result), 0);

        // Reset during LATCH discards the popped pair
        push_res(16'hdead);
        push_sta(16'h0001);
        tick();
        check("pre_reset_read", int'(en_rd_fifo_result), 1);
        tick();
        rst = 1'b0;
        #1;
        check("mid_reset_valid", int'(host_valid), 0);
        check("mid_reset_rd", int'(en_rd_fifo_result | en_rd_fifo_status), 0);
        check("mid_reset_result", int'(host_result), 0);
        check("mid_reset_status", int'(host_status), 0);
        check("mid_reset_pairs", int'(pairs_drained), 0);
        check("mid_reset_desync", int'(desync), 0);
        void'(exp_r.pop_front());
        void'(exp_s.pop_front());
        model_reset();
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_valid_after_abort", int'(host_valid), 0);
        end
        push_res(16'h5555);
        push_sta(16'h0000);
        wait_valid("post_reset_latency", 3);
        check("post_reset_result", int'(host_result), 16'h5555);
        tick();
        check("post_reset_pairs", int'(pairs_drained), 1);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            int act;
            act = int'($urandom_range(0, 7));
            if ((act == 0 || act == 2) && q_res.size() < 6) push_res(WS'($urandom));
            if ((act == 1 || act == 2) && q_sta.size() < 6) push_sta(WS'($urandom_range(0, 3)));
            host_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        while (exp_r.size() < exp_s.size()) push_res(WS'($urandom));
        while (exp_s.size() < exp_r.size()) push_sta(WS'($urandom_range(0, 3)));
        drain_all(400);
        check("random_pairs", int'(pairs_drained), mpairs);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/output_fifo_drain.md
Name: output_fifo_drain

Overview:
- Reader end of the result/status output FIFO pair that the firing-state FSM writes through its shared write enable.
- Pops one result token and one status token together, only when both FIFOs hold at least one token.
- Presents the pair to the host on a valid/ready interface.
- Counts drained pairs and flags result/status FIFO desynchronisation.

Parameters:
- word_size, 16, token width of the result FIFO, the status FIFO and the population counts
- desync_timeout, 8, consecutive cycles with exactly one FIFO non-empty before desync is flagged (minimum 1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- pop_out_fifo_result  input  word_size  result FIFO population count
- pop_out_fifo_status  input  word_size  status FIFO population count
- data_in_result  input  word_size  result FIFO read data; valid the cycle after the read enable
- data_in_status  input  word_size  status FIFO read data; valid the cycle after the read enable
- en_rd_fifo_result  output  1  result FIFO read enable
- en_rd_fifo_status  output  1  status FIFO read enable
- host_ready  input  1  host accepts the presented pair
- host_valid  output  1  pair presented to host
- host_result  output  word_size  latched result token
- host_status  output  word_size  latched status token
- pairs_drained  output  word_size  pairs accepted by host; wraps modulo 2^word_size
- desync  output  1  sticky desynchronisation flag

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0, including the counters and desync.
- States are IDLE, READ, LATCH, PRESENT. Outputs are Moore, decoded from state.
- IDLE:
  - If pop_out_fifo_result >= 1 and pop_out_fifo_status >= 1, go to READ.
  - Otherwise stay in IDLE.
- READ: en_rd_fifo_result = en_rd_fifo_status = 1 for exactly one cycle; next state LATCH.
- LATCH: capture data_in_result into host_result and data_in_status into host_status on the clock edge leaving LATCH; next state PRESENT.
- PRESENT:
  - host_valid = 1.
  - If host_ready = 1, the transfer completes: pairs_drained increments and the next state is IDLE.
  - Otherwise hold, with host_result/host_status stable.
- host_valid never drops without a completed transfer.
- Read enables are only ever asserted in READ, and always together.
- Minimum spacing with host_ready tied high: 4 cycles per pair. The first host_valid appears 3 cycles after both populations become non-zero.
- host_result/host_status keep their last value outside PRESENT.
- Desync counter:
  - Increments each cycle in which exactly one of the two populations is zero. Saturates at desync_timeout.
  - Clears whenever both populations are zero or both are non-zero.
  - desync is set when the counter reaches desync_timeout and stays set until reset.
  - desync does not block draining.
- A population change while in READ/LATCH/PRESENT has no effect until the FSM returns to IDLE.
- pairs_drained wraps from all-ones to 0.
- Reset asserted mid-transfer aborts immediately. The popped pair is discarded and no host_valid is issued.

Optional Feature:
- Macro STATUS_ERR_CNT_EN.
- When defined:
  - Adds output err_count [word_size-1:0], reset 0.
  - err_count increments, saturating at all-ones, on each completed host transfer whose host_status != 0.
- When undefined: the port is absent, with no logic and no other change.

Decomposition:
- Shared package holds:
  - the state encoding constants IDLE = 2'b00, READ = 2'b01, LATCH = 2'b10, PRESENT = 2'b11;
  - the status success code STATUS_OK = 0.
- One natural sub-module, desync_monitor: the saturating timeout counter plus the sticky flag.
- The FSM, latches and pair counter stay in the top module.

Test Plan:
1. Reset, then both populations = 1, data_in_result = 16'h0042 and data_in_status = 16'h0000 on the cycle after the read, host_ready = 1:
   - read enables are high together for exactly 1 cycle;
   - host_valid goes high 3 cycles after the populations rise, with host_result = 0042 and host_status = 0000;
   - pairs_drained = 1.
2. host_ready held 0 for 5 cycles in PRESENT:
   - host_valid stays 1 with outputs stable;
   - no further read enable occurs;
   - on host_ready = 1, pairs_drained increments once and the FSM returns to IDLE.
3. Result population = 3, status population = 0 for 8 cycles (desync_timeout = 8):
   - no read enable is asserted;
   - desync = 1 after the 8th cycle and remains 1 after the status population rises;
   - pairs are then drained normally.
4. Back-to-back pairs: both populations = 4, host_ready = 1:
   - 4 transfers occur, spaced 4 cycles apart;
   - pairs_drained = 4, then the FSM returns to IDLE when the populations reach 0.
5. rst asserted during LATCH:
   - all outputs are 0 immediately and host_valid is never asserted for that pair;
   - after release, the next pair drains normally.
6. With STATUS_ERR_CNT_EN, drain statuses 0, 3, 0, 7: err_count = 2 and pairs_drained = 4.
